// File: rtl/msg_assembly_buffer_pkg.sv
// Shared defaults and types for the message assembly buffer.
// Holds the NIC-wide bus widths used as parameter defaults.
// No logic; imported by the top and the slot storage.
package msg_assembly_buffer_pkg;

    // NIC-wide defaults for the bus interface
    localparam int NIC_ADDR_W    = 32;
    localparam int NIC_DATA_W    = 32;
    localparam int NIC_SEL_W     = 4;
    localparam int NIC_MAX_BEATS = 8;
    localparam int NIC_VNET_LSB  = 4;

    // What the fill side does with the current cycle's inputs
    typedef enum logic [1:0] {
        BEAT_NONE  = 2'd0,  // no accepted beat, no abort
        BEAT_STORE = 2'd1,  // accepted beat written at the fill index
        BEAT_DROP  = 2'd2,  // accepted beat beyond MAX_BEATS, data discarded
        BEAT_ABORT = 2'd3   // partial message discarded, any beat ignored
    } beat_act_e;

endpackage

// File: rtl/msg_slot_array.sv
// Per-slot message storage: address, write flag, length, beat data and selects.
// Writes land on the clock edge; read side is a combinational mux on i_rd_slot.
// No backpressure of its own; the top decides when writes and clears happen.
module msg_slot_array
    import msg_assembly_buffer_pkg::*;
#(
    parameter int N_SLOTS   = 4,
    parameter int MAX_BEATS = NIC_MAX_BEATS,
    parameter int ADDR_W    = NIC_ADDR_W,
    parameter int DATA_W    = NIC_DATA_W,
    parameter int SEL_W     = NIC_SEL_W,
    parameter int PTR_W     = $clog2(N_SLOTS),
    parameter int BIDX_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
    parameter int LEN_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    // fill side
    input  logic [PTR_W-1:0]            i_wr_slot,
    input  logic [BIDX_W-1:0]           i_wr_idx,
    input  logic                        i_beat_en,
    input  logic [DATA_W-1:0]           i_dat,
    input  logic [SEL_W-1:0]            i_sel,
    input  logic                        i_hdr_en,
    input  logic [ADDR_W-1:0]           i_adr,
    input  logic                        i_we,
    input  logic                        i_len_en,
    input  logic [LEN_W-1:0]            i_len,
    // two independent select-clear ports (abort on fill slot, pop on read slot)
    input  logic                        i_clr_a_en,
    input  logic [PTR_W-1:0]            i_clr_a_slot,
    input  logic                        i_clr_b_en,
    input  logic [PTR_W-1:0]            i_clr_b_slot,
    // read side
    input  logic [PTR_W-1:0]            i_rd_slot,
    output logic [ADDR_W-1:0]           o_adr,
    output logic                        o_we,
    output logic [LEN_W-1:0]            o_len,
    output logic [MAX_BEATS*DATA_W-1:0] o_dat,
    output logic [MAX_BEATS*SEL_W-1:0]  o_sel
);

    logic [ADDR_W-1:0] r_adr [N_SLOTS];
    logic [N_SLOTS-1:0] r_we;
    logic [LEN_W-1:0]  r_len [N_SLOTS];
    logic [DATA_W-1:0] r_dat [N_SLOTS][MAX_BEATS];
    logic [SEL_W-1:0]  r_sel [N_SLOTS][MAX_BEATS];

    // Payload storage is left unreset; selects and the counters elsewhere say what is valid
    always_ff @(posedge clk) begin
        if (i_hdr_en) begin
            r_adr[i_wr_slot] <= i_adr;
            r_we[i_wr_slot]  <= i_we;
        end
        if (i_len_en) begin
            r_len[i_wr_slot] <= i_len;
        end
        if (i_beat_en) begin
            r_dat[i_wr_slot][i_wr_idx] <= i_dat;
        end
    end

    // Selects are zero unless a beat was stored there, so they mark valid bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                for (int b = 0; b < MAX_BEATS; b++) begin
                    r_sel[s][b] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < N_SLOTS; s++) begin
                if ((i_clr_a_en && (i_clr_a_slot == PTR_W'(s))) ||
                    (i_clr_b_en && (i_clr_b_slot == PTR_W'(s)))) begin
                    for (int b = 0; b < MAX_BEATS; b++) begin
                        r_sel[s][b] <= '0;
                    end
                end
            end
            if (i_beat_en) begin
                r_sel[i_wr_slot][i_wr_idx] <= i_sel;
            end
        end
    end

    // Flatten the head slot's beats onto the packed output buses
    always_comb begin
        o_dat = '0;
        o_sel = '0;
        for (int b = 0; b < MAX_BEATS; b++) begin
            o_dat[b*DATA_W +: DATA_W] = r_dat[i_rd_slot][b];
            o_sel[b*SEL_W +: SEL_W]   = r_sel[i_rd_slot][b];
        end
    end

    assign o_adr = r_adr[i_rd_slot];
    assign o_we  = r_we[i_rd_slot];
    assign o_len = r_len[i_rd_slot];

endmodule

// File: rtl/msg_assembly_buffer.sv
// Assembles beats into whole messages held in N_SLOTS slots, presented in FIFO order.
// A completed message is visible on msg_valid_o the cycle after its last beat.
// beat_ready_o drops only when all slots hold complete messages; it depends on registered count only.
module msg_assembly_buffer
    import msg_assembly_buffer_pkg::*;
#(
    parameter int N_SLOTS        = 4,
    parameter int MAX_BEATS      = NIC_MAX_BEATS,
    parameter int N_BITS_VNET_ID = 2,
    parameter int VNET_LSB       = NIC_VNET_LSB,
    parameter int ADDR_W         = NIC_ADDR_W,
    parameter int DATA_W         = NIC_DATA_W,
    parameter int SEL_W          = NIC_SEL_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                adr_i,
    input  logic [DATA_W-1:0]                dat_i,
    input  logic [SEL_W-1:0]                 sel_i,
    input  logic                             we_i,
    input  logic                             beat_valid_i,
    input  logic                             beat_last_i,
    output logic                             beat_ready_o,
    input  logic                             abort_i,
    output logic                             msg_valid_o,
    input  logic                             msg_ready_i,
    output logic [ADDR_W-1:0]                msg_adr_o,
    output logic                             msg_we_o,
    output logic [MAX_BEATS*DATA_W-1:0]      msg_dat_o,
    output logic [MAX_BEATS*SEL_W-1:0]       msg_sel_o,
    output logic [$clog2(MAX_BEATS+1)-1:0]   msg_len_o,
    output logic [N_BITS_VNET_ID-1:0]        msg_vnet_o,
    output logic                             overflow_o,
    output logic [$clog2(N_SLOTS+1)-1:0]     count_o
);

    localparam int PTR_W  = $clog2(N_SLOTS);
    localparam int LEN_W  = $clog2(MAX_BEATS + 1);
    localparam int CNT_W  = $clog2(N_SLOTS + 1);
    localparam int BIDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [LEN_W-1:0] r_fill_idx;
    logic             r_overflow;

    beat_act_e        w_act;
    logic             w_full;
    logic             w_pop;
    logic             w_room;
    logic             w_complete;
    logic             w_beat_en;
    logic             w_hdr_en;
    logic             w_abort_clr;
    logic [LEN_W-1:0] w_len;

    assign w_full       = (r_count == CNT_W'(N_SLOTS));
    assign beat_ready_o = !w_full;
    assign msg_valid_o  = (r_count != '0);
    assign w_pop        = msg_valid_o && msg_ready_i;
    assign w_room       = (r_fill_idx < LEN_W'(MAX_BEATS));

    // Classify this cycle's fill-side activity; abort wins over any beat
    always_comb begin
        w_act = BEAT_NONE;
        if (abort_i) begin
            w_act = BEAT_ABORT;
        end else if (beat_valid_i && beat_ready_o) begin
            w_act = w_room ? BEAT_STORE : BEAT_DROP;
        end
    end

    assign w_complete  = ((w_act == BEAT_STORE) || (w_act == BEAT_DROP)) && beat_last_i;
    assign w_beat_en   = (w_act == BEAT_STORE);
    assign w_hdr_en    = w_beat_en && (r_fill_idx == '0);
    assign w_len       = w_room ? (r_fill_idx + LEN_W'(1)) : LEN_W'(MAX_BEATS);
    // When full the write slot is the head message, so it must not be cleared
    assign w_abort_clr = (w_act == BEAT_ABORT) && !w_full;

    // Pointers, message count, fill index and the registered overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fill_idx <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= (w_act == BEAT_DROP);
            if ((w_act == BEAT_ABORT) || w_complete) begin
                r_fill_idx <= '0;
            end else if (w_beat_en) begin
                r_fill_idx <= r_fill_idx + LEN_W'(1);
            end
            if (w_complete) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_complete, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    msg_slot_array #(
        .N_SLOTS   (N_SLOTS),
        .MAX_BEATS (MAX_BEATS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .SEL_W     (SEL_W),
        .PTR_W     (PTR_W),
        .BIDX_W    (BIDX_W),
        .LEN_W     (LEN_W)
    ) u_slots (
        .clk          (clk),
        .rst          (rst),
        .i_wr_slot    (r_wr_ptr),
        .i_wr_idx     (r_fill_idx[BIDX_W-1:0]),
        .i_beat_en    (w_beat_en),
        .i_dat        (dat_i),
        .i_sel        (sel_i),
        .i_hdr_en     (w_hdr_en),
        .i_adr        (adr_i),
        .i_we         (we_i),
        .i_len_en     (w_complete),
        .i_len        (w_len),
        .i_clr_a_en   (w_abort_clr),
        .i_clr_a_slot (r_wr_ptr),
        .i_clr_b_en   (w_pop),
        .i_clr_b_slot (r_rd_ptr),
        .i_rd_slot    (r_rd_ptr),
        .o_adr        (msg_adr_o),
        .o_we         (msg_we_o),
        .o_len        (msg_len_o),
        .o_dat        (msg_dat_o),
        .o_sel        (msg_sel_o)
    );

    assign msg_vnet_o = msg_adr_o[VNET_LSB +: N_BITS_VNET_ID];
    assign overflow_o = r_overflow;
    assign count_o    = r_count;

endmodule

// File: tb/tb_msg_assembly_buffer.sv
// Directed bench for msg_assembly_buffer with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Each scenario task does its own comparisons and bumps the shared counters.
module tb_msg_assembly_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  adr_i = '0;
    logic [31:0]  dat_i = '0;
    logic [3:0]   sel_i = '0;
    logic         we_i = 1'b0;
    logic         beat_valid_i = 1'b0;
    logic         beat_last_i = 1'b0;
    logic         beat_ready_o;
    logic         abort_i = 1'b0;
    logic         msg_valid_o;
    logic         msg_ready_i = 1'b0;
    logic [31:0]  msg_adr_o;
    logic         msg_we_o;
    logic [255:0] msg_dat_o;
    logic [31:0]  msg_sel_o;
    logic [3:0]   msg_len_o;
    logic [1:0]   msg_vnet_o;
    logic         overflow_o;
    logic [2:0]   count_o;

    int checks = 0;
    int errors = 0;

    msg_assembly_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .adr_i        (adr_i),
        .dat_i        (dat_i),
        .sel_i        (sel_i),
        .we_i         (we_i),
        .beat_valid_i (beat_valid_i),
        .beat_last_i  (beat_last_i),
        .beat_ready_o (beat_ready_o),
        .abort_i      (abort_i),
        .msg_valid_o  (msg_valid_o),
        .msg_ready_i  (msg_ready_i),
        .msg_adr_o    (msg_adr_o),
        .msg_we_o     (msg_we_o),
        .msg_dat_o    (msg_dat_o),
        .msg_sel_o    (msg_sel_o),
        .msg_len_o    (msg_len_o),
        .msg_vnet_o   (msg_vnet_o),
        .overflow_o   (overflow_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat for one clock, then withdraw it
    task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic l);
        adr_i = a; dat_i = d; sel_i = s; we_i = 1'b1;
        beat_valid_i = 1'b1; beat_last_i = l;
        tick();
        beat_valid_i = 1'b0; beat_last_i = 1'b0;
    endtask

    task automatic pop();
        msg_ready_i = 1'b1;
        tick();
        msg_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
        checks++; if (msg_valid_o !== 1'b0) begin errors++; $display("FAIL reset_msg_valid got %b exp 0", msg_valid_o); end
        checks++; if (beat_ready_o !== 1'b1) begin errors++; $display("FAIL reset_beat_ready got %b exp 1", beat_ready_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow_o); end
        checks++; if (msg_sel_o !== 32'h0) begin errors++; $display("FAIL reset_sel got %h exp 0", msg_sel_o); end
    endtask

    task automatic test_basic_write();
        msg_ready_i = 1'b1;
        beat(32'h30, 32'hA0, 4'hF, 1'b0);
        checks++; if (msg_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", msg_valid_o); end
        beat(32'h30, 32'hA1, 4'hF, 1'b0);
        beat(32'h30, 32'hA2, 4'hF, 1'b1);
        checks++; if (msg_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", msg_valid_o); end
        checks++; if (msg_len_o !== 4'd3) begin errors++; $display("FAIL basic_len got %0d exp 3", msg_len_o); end
        checks++; if (msg_vnet_o !== 2'd3) begin errors++; $display("FAIL basic_vnet got %0d exp 3", msg_vnet_o); end
        checks++; if (msg_adr_o !== 32'h30) begin errors++; $display("FAIL basic_adr got %h exp 30", msg_adr_o); end
        checks++; if (msg_we_o !== 1'b1) begin errors++; $display("FAIL basic_we got %b exp 1", msg_we_o); end
        checks++; if (msg_dat_o[95:0] !== 96'h000000A2_000000A1_000000A0) begin errors++; $display("FAIL basic_dat got %h exp a2a1a0", msg_dat_o[95:0]); end
        checks++; if (msg_sel_o !== 32'h00000FFF) begin errors++; $display("FAIL basic_sel got %h exp 00000fff", msg_sel_o); end
        tick();
        msg_ready_i = 1'b0;
        checks++; if (msg_valid_o !== 1'b0) begin errors++; $display("FAIL basic_popped got %b exp 0", msg_valid_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL basic_count got %0d exp 0", count_o); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            beat(32'h100 + 32'(i), 32'h11 + 32'(i), 4'h1, 1'b1);
        end
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count_o); end
        checks++; if (beat_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", beat_ready_o); end
        beat(32'h200, 32'h99, 4'h1, 1'b1);
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_fifth_count got %0d exp 4", count_o); end
        checks++; if (msg_dat_o[31:0] !== 32'h11) begin errors++; $display("FAIL full_head got %h exp 11", msg_dat_o[31:0]); end
        pop();
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d exp 3", count_o); end
        checks++; if (beat_ready_o !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %b exp 1", beat_ready_o); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (msg_dat_o[31:0] !== 32'h11 + 32'(i)) begin errors++; $display("FAIL full_order got %h exp %h", msg_dat_o[31:0], 32'h11 + 32'(i)); end
            pop();
        end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", count_o); end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        for (int k = 0; k < 10; k++) begin
            beat(32'h40, 32'h1000 + 32'(k), 4'hF, (k == 9));
            if (overflow_o === 1'b1) pulses++;
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL ovf_pulses got %0d exp 2", pulses); end
        checks++; if (msg_len_o !== 4'd8) begin errors++; $display("FAIL ovf_len got %0d exp 8", msg_len_o); end
        for (int b = 0; b < 8; b++) begin
            checks++; if (msg_dat_o[b*32 +: 32] !== 32'h1000 + 32'(b)) begin errors++; $display("FAIL ovf_beat%0d got %h exp %h", b, msg_dat_o[b*32 +: 32], 32'h1000 + 32'(b)); end
        end
        checks++; if (msg_sel_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL ovf_sel got %h exp ffffffff", msg_sel_o); end
        tick();
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow_o); end
        pop();
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL ovf_drain got %0d exp 0", count_o); end
    endtask

    task automatic test_abort();
        beat(32'h50, 32'hB0, 4'hF, 1'b0);
        beat(32'h50, 32'hB1, 4'hF, 1'b0);
        abort_i = 1'b1;
        adr_i = 32'h50; dat_i = 32'hEE; sel_i = 4'hF;
        beat_valid_i = 1'b1; beat_last_i = 1'b1;
        tick();
        abort_i = 1'b0; beat_valid_i = 1'b0; beat_last_i = 1'b0;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL abort_count got %0d exp 0", count_o); end
        beat(32'h20, 32'hC0, 4'h3, 1'b1);
        checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL abort_msg_count got %0d exp 1", count_o); end
        checks++; if (msg_adr_o !== 32'h20) begin errors++; $display("FAIL abort_adr got %h exp 20", msg_adr_o); end
        checks++; if (msg_vnet_o !== 2'd2) begin errors++; $display("FAIL abort_vnet got %0d exp 2", msg_vnet_o); end
        checks++; if (msg_len_o !== 4'd1) begin errors++; $display("FAIL abort_len got %0d exp 1", msg_len_o); end
        checks++; if (msg_dat_o[31:0] !== 32'hC0) begin errors++; $display("FAIL abort_dat got %h exp c0", msg_dat_o[31:0]); end
        checks++; if (msg_sel_o !== 32'h00000003) begin errors++; $display("FAIL abort_sel got %h exp 00000003", msg_sel_o); end
        pop();
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL abort_drain got %0d exp 0", count_o); end
    endtask

    task automatic test_back_to_back();
        beat(32'h0, 32'h21, 4'h1, 1'b1);
        beat(32'h0, 32'h22, 4'h1, 1'b1);
        beat(32'h0, 32'h23, 4'h1, 1'b1);
        beat(32'h0, 32'h24, 4'h1, 1'b0);
        // last beat of the 4th message together with a pop
        adr_i = 32'h0; dat_i = 32'h25; sel_i = 4'h1;
        beat_valid_i = 1'b1; beat_last_i = 1'b1; msg_ready_i = 1'b1;
        tick();
        beat_valid_i = 1'b0; beat_last_i = 1'b0; msg_ready_i = 1'b0;
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL b2b_same_count got %0d exp 3", count_o); end
        checks++; if (msg_dat_o[31:0] !== 32'h22) begin errors++; $display("FAIL b2b_head got %h exp 22", msg_dat_o[31:0]); end
        beat(32'h0, 32'h26, 4'h1, 1'b1);
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL b2b_full got %0d exp 4", count_o); end
        // full: beat held while a pop frees a slot
        dat_i = 32'h27; beat_valid_i = 1'b1; beat_last_i = 1'b1; msg_ready_i = 1'b1;
        tick();
        msg_ready_i = 1'b0;
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL b2b_pop_count got %0d exp 3", count_o); end
        checks++; if (beat_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise got %b exp 1", beat_ready_o); end
        tick();
        beat_valid_i = 1'b0; beat_last_i = 1'b0;
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL b2b_refill got %0d exp 4", count_o); end
        checks++; if (msg_dat_o[31:0] !== 32'h23) begin errors++; $display("FAIL b2b_order0 got %h exp 23", msg_dat_o[31:0]); end
        pop();
        checks++; if (msg_len_o !== 4'd2) begin errors++; $display("FAIL b2b_len got %0d exp 2", msg_len_o); end
        checks++; if (msg_dat_o[63:0] !== 64'h00000025_00000024) begin errors++; $display("FAIL b2b_order1 got %h exp 2524", msg_dat_o[63:0]); end
        pop();
        checks++; if (msg_dat_o[31:0] !== 32'h26) begin errors++; $display("FAIL b2b_order2 got %h exp 26", msg_dat_o[31:0]); end
        pop();
        checks++; if (msg_dat_o[31:0] !== 32'h27) begin errors++; $display("FAIL b2b_order3 got %h exp 27", msg_dat_o[31:0]); end
        pop();
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", count_o); end
    endtask

    task automatic test_mid_reset();
        beat(32'h60, 32'h31, 4'hF, 1'b1);
        beat(32'h70, 32'h32, 4'hF, 1'b1);
        beat(32'h80, 32'h33, 4'hF, 1'b0);
        rst = 1'b1;
        adr_i = 32'h80; dat_i = 32'h34; sel_i = 4'hF; beat_valid_i = 1'b1; msg_ready_i = 1'b1;
        tick();
        rst = 1'b0; beat_valid_i = 1'b0; msg_ready_i = 1'b0;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL mrst_count got %0d exp 0", count_o); end
        checks++; if (msg_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b exp 0", msg_valid_o); end
        checks++; if (beat_ready_o !== 1'b1) begin errors++; $display("FAIL mrst_ready got %b exp 1", beat_ready_o); end
        beat(32'h90, 32'h35, 4'hF, 1'b1);
        checks++; if (msg_adr_o !== 32'h90) begin errors++; $display("FAIL mrst_adr got %h exp 90", msg_adr_o); end
        checks++; if (msg_len_o !== 4'd1) begin errors++; $display("FAIL mrst_len got %0d exp 1", msg_len_o); end
        checks++; if (msg_dat_o[31:0] !== 32'h35) begin errors++; $display("FAIL mrst_dat got %h exp 35", msg_dat_o[31:0]); end
        checks++; if (msg_sel_o !== 32'h0000000F) begin errors++; $display("FAIL mrst_sel got %h exp 0000000f", msg_sel_o); end
        pop();
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_full();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
